// File: rtl/priority_arbiter_4.sv
// rtl/priority_arbiter_4.sv - four-requester grant-holding arbiter for one shared resource
//
// Purpose: picks one of four requesters, registers it as a one-hot grant plus
// a binary ID, and holds the grant until done, owner withdrawal, or hold timeout.
// Optional feature macro: ROUND_ROBIN_EN (rotating priority starting below the
// last owner); undefined gives strict fixed priority 3 > 2 > 1 > 0.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   req[3:0]     request lines, req[i]=1 means requester i wants the resource
//   done         owner release strobe, only looked at while busy
//   gnt[3:0]     registered one-hot grant
//   gnt_id[1:0]  registered owner index, 0 when idle
//   busy         registered, 1 while a grant is active
//   timeout_err  registered one-cycle pulse on a forced release
module priority_arbiter_4 #(
  parameter int TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] gnt,
  output logic [1:0] gnt_id,
  output logic       busy,
  output logic       timeout_err
);

  typedef enum logic {IDLE, GRANT} state_t;

`ifdef ROUND_ROBIN_EN
  localparam bit ROTATE = 1'b1;
`else
  localparam bit ROTATE = 1'b0;
`endif

  // Value of hcnt on the last permitted grant cycle.
  localparam logic [7:0] TLAST = 8'(TIMEOUT - 1);

  state_t     state;
  logic [7:0] hcnt;
  logic [1:0] owner;
  logic [1:0] lptr;

  logic [1:0] base;
  logic [1:0] idx;
  logic [1:0] win;
  logic       rel_normal;
  logic       rel_timeout;

  // The search walks base-1, base-2, base-3, base. With base=0 that is the
  // fixed order 3, 2, 1, 0, so both modes share one selector.
  assign base = ROTATE ? lptr : 2'b00;

  // Visit the lowest priority first so the highest-priority hit is the last
  // assignment and wins.
  always_comb begin
    win = 2'd0;
    idx = 2'd0;
    for (int i = 4; i >= 1; i--) begin
      idx = base - 2'(i);
      if (req[idx]) win = idx;
    end
  end

  // done and withdrawal take precedence over the timeout in the same cycle.
  assign rel_normal  = done || !req[owner];
  assign rel_timeout = (TIMEOUT != 0) && (hcnt == TLAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      gnt         <= 4'b0000;
      gnt_id      <= 2'd0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
      hcnt        <= 8'd0;
      owner       <= 2'd0;
      lptr        <= 2'd0;
    end else begin
      timeout_err <= 1'b0;
      if (state == IDLE) begin
        if (|req) begin
          state  <= GRANT;
          gnt    <= 4'b0001 << win;
          gnt_id <= win;
          owner  <= win;
          busy   <= 1'b1;
          hcnt   <= 8'd0;
        end
      end else begin
        if (rel_normal || rel_timeout) begin
          state       <= IDLE;
          gnt         <= 4'b0000;
          gnt_id      <= 2'd0;
          busy        <= 1'b0;
          hcnt        <= 8'd0;
          lptr        <= owner;
          timeout_err <= !rel_normal;
        end else if (hcnt != 8'hff) begin
          hcnt <= hcnt + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_priority_arbiter_4.sv
// tb/tb_priority_arbiter_4.sv - self-checking bench for priority_arbiter_4
module tb_priority_arbiter_4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req_a, req_b;
  logic       done_a, done_b;
  logic [3:0] gnt_a, gnt_b;
  logic [1:0] gnt_id_a, gnt_id_b;
  logic       busy_a, busy_b;
  logic       terr_a, terr_b;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] exp_q [$];
  string      tag_q [$];

`ifdef ROUND_ROBIN_EN
  int rot_exp [5] = '{3, 2, 1, 0, 3};
`else
  int rot_exp [5] = '{3, 3, 3, 3, 3};
`endif

  always #5 clk = ~clk;

  priority_arbiter_4 #(.TIMEOUT(4)) dut_a (
    .clk(clk), .rst(rst), .req(req_a), .done(done_a),
    .gnt(gnt_a), .gnt_id(gnt_id_a), .busy(busy_a), .timeout_err(terr_a)
  );

  priority_arbiter_4 #(.TIMEOUT(0)) dut_b (
    .clk(clk), .rst(rst), .req(req_b), .done(done_b),
    .gnt(gnt_b), .gnt_id(gnt_id_b), .busy(busy_b), .timeout_err(terr_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of stimulus on dut_a, queue the outputs expected after the
  // next edge, then compare them against the DUT.
  task automatic cyc(input string tag, input logic [3:0] r, input logic d,
                     input logic [3:0] eg, input logic [1:0] eid,
                     input logic eb, input logic et);
    logic [7:0] e;
    string      t;
    req_a  = r;
    done_a = d;
    exp_q.push_back({eg, eid, eb, et});
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    check({t, ".gnt"},    gnt_a,    e[7:4]);
    check({t, ".gnt_id"}, gnt_id_a, e[3:2]);
    check({t, ".busy"},   busy_a,   e[1]);
    check({t, ".terr"},   terr_a,   e[0]);
  endtask

  // Assert reset between edges; outputs must clear without waiting for a clock.
  task automatic do_reset(input string tag);
    #3;
    rst = 1'b1;
    #1;
    check({tag, ".gnt"},    gnt_a,    4'b0000);
    check({tag, ".gnt_id"}, gnt_id_a, 2'd0);
    check({tag, ".busy"},   busy_a,   1'b0);
    check({tag, ".terr"},   terr_a,   1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst    = 1'b1;
    req_a  = 4'b0000;
    req_b  = 4'b0000;
    done_a = 1'b0;
    done_b = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("reset.gnt",    gnt_a,      4'b0000);
    check("reset.gnt_id", gnt_id_a,   2'd0);
    check("reset.busy",   busy_a,     1'b0);
    check("reset.terr",   terr_a,     1'b0);
    check("reset.lptr",   dut_a.lptr, 2'd0);
    rst = 1'b0;

    // Idle with no requests, done ignored
    cyc("idle",    4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0);

    // Fixed priority
    cyc("fp0",     4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0);
    cyc("fp0_rel", 4'b0001, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0);
    cyc("fp2",     4'b0101, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0);
    cyc("fp2_rel", 4'b0101, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0);

    // Reset mid-grant, then a fresh grant
    cyc("pre_rst", 4'b1000, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0);
    do_reset("rst_mid");
    cyc("post_rst",4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0);
    cyc("nonown",  4'b1111, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0);
    cyc("post_rel",4'b0100, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0);
    do_reset("rst_idle");

    cyc("fp3",     4'b1101, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0);
    // done release, one dead cycle, then regrant
    cyc("done_rel",4'b0011, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0);
    cyc("after_dn",4'b0011, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0);
    // owner withdrawal
    cyc("wd_rel",  4'b0001, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0);
    cyc("after_wd",4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0);
    cyc("wd_rel2", 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0);

    // Timeout = 4 grant cycles
    cyc("to_g1",   4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++)
      cyc("to_hold", 4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0);
    cyc("to_fire", 4'b0010, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b1);
    cyc("to_regnt",4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++)
      cyc("to_hold2", 4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0);
    // done on the last grant cycle wins over the timeout
    cyc("to_done", 4'b0010, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0);
    do_reset("rst_rot");

    // Rotation with all requesters active
    for (int i = 0; i < 5; i++) begin
      cyc("rot_gnt", 4'b1111, 1'b0, 4'(1 << rot_exp[i]), 2'(rot_exp[i]), 1'b1, 1'b0);
      cyc("rot_rel", 4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0);
    end

    // Disabled timeout: grant held for 300 cycles, counter saturates
    req_a = 4'b0000;
    req_b = 4'b0001;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      #1;
      check("notmo.gnt",  gnt_b,  4'b0001);
      check("notmo.terr", terr_b, 1'b0);
    end
    check("notmo.busy", busy_b,     1'b1);
    check("notmo.hcnt", dut_b.hcnt, 8'hff);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
